demux2_32b_buf: RTL
===================

Name: demux2_32b_buf

Overview:
- Reverse-direction companion to the 2:1 32-bit select mux used in IF/ID/WB.
- Takes one 32-bit result stream and steers each word to one of two consumer ports by a per-word select. Typical targets: port 0 = WB register-file write path, port 1 = forwarding/store path.
- Each output has a small FIFO, so one stalled consumer does not block words bound for the other until its own FIFO fills.
- Valid/ready handshake on every port.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO. Legal values 2 or 4 (power of two).
- CNT_W, 2, occupancy counter width. Must hold values 0..DEPTH, so it is 3 when DEPTH=4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  word to route.
- in_sel  in  1  destination: 0 -> out0, 1 -> out1.
- in_valid  in  1  input word present.
- in_ready  out  1  input accepted this cycle when in_valid & in_ready.
- out0_data  out  WIDTH  head word of FIFO 0.
- out0_valid  out  1  FIFO 0 non-empty.
- out0_ready  in  1  consumer 0 takes head.
- out1_data  out  WIDTH  head word of FIFO 1.
- out1_valid  out  1  FIFO 1 non-empty.
- out1_ready  in  1  consumer 1 takes head.
- out0_count  out  CNT_W  FIFO 0 occupancy, 0..DEPTH.
- out1_count  out  CNT_W  FIFO 1 occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both FIFOs empty; pointers and counts = 0.
  - outX_valid = 0, outX_data = 0, outX_count = 0.
  - in_ready = 0 while rst_n=0 and 1 from the first cycle after release.
- in_ready is combinational from the selected FIFO only:
  - in_ready = !full[in_sel] | (full[in_sel] & outX_ready of that port). Full-and-popping accepts in the same cycle.
  - in_ready must not depend on in_valid.
  - The non-selected FIFO's state never affects in_ready.
- Push: on in_valid & in_ready, in_data is written at the wr_ptr of FIFO[in_sel]. wr_ptr increments mod DEPTH.
- Pop: on outX_valid & outX_ready, rd_ptr of FIFO X increments mod DEPTH.
- Count: count += push - pop per FIFO. Simultaneous push and pop on the same FIFO leaves count unchanged.
- Latency:
  - A word pushed into an empty FIFO at edge N is visible with outX_valid=1 after edge N, i.e. one-cycle latency.
  - There is no combinational in->out bypass.
- outX_data = mem[rd_ptr] (registered storage, combinational read).
  - Stable while outX_valid=1 and outX_ready=0.
  - Value is don't-care when outX_valid=0; it reads stale memory, not forced to 0 after reset activity.
- Ordering: words to the same output leave in acceptance order. There is no ordering relation between outputs.
- Pointer wrap: pointers wrap DEPTH-1 -> 0. full = (count==DEPTH), empty = (count==0).
- Upstream rule: in_sel and in_data are sampled only on acceptance. While in_valid=1 and in_ready=0, upstream must hold both in_data and in_sel (protocol rule; bench asserts it).
- Reset mid-operation: all stored words are discarded immediately. No partial state survives.
- No overflow or underflow is possible by construction. The bench asserts count never exceeds DEPTH and never wraps below 0.

Decomposition:
- Shared header defines: WIDTH default 32, DEPTH default 2, and SEL_OUT0=1'b0 / SEL_OUT1=1'b1 select constants.
- One natural sub-module: fifo_sync_nd, a single-clock DEPTH-entry FIFO with push/pop/full/empty/count. It is instantiated twice.
- The top level holds only the select steering and in_ready logic.

Test Plan:
1. Reset, then push 0xDEADBEEF sel=0 with out0_ready=1 -> out0_valid=1 with 0xDEADBEEF on the next cycle, popped the same cycle; out1_valid stays 0; counts return to 0.
2. out0_ready=0; push 0x11, 0x22 to sel=0 -> out0_count=2, in_ready=0 for sel=0. Then present 0x33 sel=1 -> accepted immediately; out1_data=0x33 next cycle; FIFO 0 unchanged.
3. FIFO 0 full (0x11, 0x22); raise out0_ready and push 0x44 sel=0 in the same cycle -> accepted; count stays 2; drain order is 0x22 then 0x44 after the 0x11 pop.
4. Stream 8 words 0x0..0x7 alternating sel 0/1 with both readies toggling pseudo-randomly -> out0 sees 0,2,4,6 and out1 sees 1,3,5,7, in order; no loss or duplication; pointers wrap at least twice.
5. Fill both FIFOs, then pulse rst_n low mid-cycle -> outputs clear asynchronously (valid=0, count=0) without waiting for clk; in_ready=0 during reset and 1 after release.
6. Hold in_valid=1 on 0x55 sel=1 with FIFO 1 full and out1_ready=0 for 5 cycles -> in_ready=0 throughout and no write occurs. Release out1_ready -> 0x55 is accepted on that cycle and appears at the FIFO tail.

Source files
------------

// File: rtl/demux2_32b_buf_pkg.sv
// Shared definitions for the 1:2 result-stream demux with per-output FIFOs.
package demux2_32b_buf_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 2;

    // Destination select encoding carried alongside each word.
    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } sel_e;

endpackage

// File: rtl/demux2_32b_buf_if.sv
// Bus bundle for the demux: one upstream stream, two downstream streams.
interface demux2_32b_buf_if
    import demux2_32b_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [CNT_W-1:0] out0_count;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] out1_count;

    // Upstream producer plus both consumers, seen from outside the demux.
    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out0_count,
               out1_data, out1_valid, out1_count
    );

    // The demux itself.
    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out0_count,
               out1_data, out1_valid, out1_count
    );
endinterface

// File: rtl/demux2_32b_buf_fifo_sync_nd.sv
// Single-clock DEPTH-entry FIFO with registered storage and combinational head read.
module fifo_sync_nd
    import demux2_32b_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    // A full FIFO may still take a word when its head leaves on the same edge.
    assign do_push   = push & (~full | pop);
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Storage write; cleared on reset so the head reads 0 until first written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer advance with explicit wrap at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: push and pop on the same edge cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux2_32b_buf.sv
// Steers one result stream to two buffered consumer ports by a per-word select.
module demux2_32b_buf
    import demux2_32b_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    demux2_32b_buf_if.slave  bus
);
    logic             run_q;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic             sel_full;
    logic             sel_draining;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;

    // Holds in_ready low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Ready looks only at the selected FIFO so the other port cannot stall it.
    always_comb begin
        sel_full     = full0;
        sel_draining = bus.out0_ready;
        if (sel_e'(bus.in_sel) == SEL_OUT1) begin
            sel_full     = full1;
            sel_draining = bus.out1_ready;
        end
    end

    assign bus.in_ready = run_q & (~sel_full | sel_draining);
    assign accept       = bus.in_valid & bus.in_ready;
    assign push0        = accept & (sel_e'(bus.in_sel) == SEL_OUT0);
    assign push1        = accept & (sel_e'(bus.in_sel) == SEL_OUT1);
    assign pop0         = ~empty0 & bus.out0_ready;
    assign pop1         = ~empty1 & bus.out1_ready;

    assign bus.out0_valid = ~empty0;
    assign bus.out1_valid = ~empty1;

    fifo_sync_nd #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (bus.in_data),
        .pop       (pop0),
        .head_data (bus.out0_data),
        .full      (full0),
        .empty     (empty0),
        .count     (bus.out0_count)
    );

    fifo_sync_nd #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (bus.in_data),
        .pop       (pop1),
        .head_data (bus.out1_data),
        .full      (full1),
        .empty     (empty1),
        .count     (bus.out1_count)
    );

endmodule
